// File: rtl/bus_arbiter.sv
// N-master, single-slave bus arbiter. Registered one-hot grant, fixed-priority or
// round-robin selection, lock with a burst limit, and an ack timeout with error return.
module bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned DW          = 8,
  parameter int unsigned AW          = 16,
  parameter int unsigned RR_MODE     = 0,
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_MASTERS-1:0]    i_req,
  input  logic [NUM_MASTERS-1:0]    i_lock,
  input  logic [NUM_MASTERS*AW-1:0] i_m_addr,
  input  logic [NUM_MASTERS*DW-1:0] i_m_dat,
  input  logic [NUM_MASTERS-1:0]    i_m_we,
  output logic [DW-1:0]             o_m_dat,
  output logic [NUM_MASTERS-1:0]    o_m_ack,
  output logic [NUM_MASTERS-1:0]    o_m_err,
  output logic [NUM_MASTERS-1:0]    o_grant,
  output logic [AW-1:0]             o_addr,
  output logic [DW-1:0]             o_dat,
  output logic                      o_we,
  output logic                      o_cs,
  input  logic [DW-1:0]             i_dat,
  input  logic                      i_ack
);

  localparam int unsigned N  = NUM_MASTERS;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = 8;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] burst_q, burst_d;
  logic [CW-1:0] tmo_q, tmo_d;

  logic          busy, cs, ack, err, locked, limit, do_arb;
  logic [N-1:0]  arb_req;
  logic [IW-1:0] win_idx;
  logic          win_vld;
  int unsigned   k;

  // Slave-side view of the granted master
  assign busy    = (state_q == BUSY);
  assign cs      = busy & i_req[gidx_q];
  assign ack     = cs & i_ack;
  assign err     = cs & ~i_ack & (tmo_q == CW'(TIMEOUT));

  assign o_cs    = cs;
  assign o_we    = cs & i_m_we[gidx_q];
  assign o_addr  = busy ? i_m_addr[gidx_q*AW +: AW] : '0;
  assign o_dat   = busy ? i_m_dat[gidx_q*DW +: DW] : '0;
  assign o_m_dat = i_dat;
  assign o_m_ack = ack ? grant_q : '0;
  assign o_m_err = err ? grant_q : '0;
  assign o_grant = grant_q;

  // Winner selection; a locked master at its burst limit steps aside if anyone else waits
  always_comb begin
    locked  = busy & i_lock[gidx_q] & i_req[gidx_q];
    limit   = (burst_q >= CW'(MAX_BURST - 1));
    arb_req = i_req;
    if (locked && limit && ((i_req & ~grant_q) != '0)) begin
      arb_req = i_req & ~grant_q;
    end
    win_vld = 1'b0;
    win_idx = '0;
    k       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (RR_MODE != 0) ? ((32'(ptr_q) + i) % N) : i;
      if (!win_vld && arb_req[IW'(k)]) begin
        win_vld = 1'b1;
        win_idx = IW'(k);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    tmo_d   = tmo_q;
    do_arb  = 1'b0;
    case (state_q)
      IDLE: do_arb = 1'b1;
      BUSY: begin
        if (!cs) begin
          do_arb = 1'b1;
        end else if (ack || err) begin
          if (locked && !limit) begin
            burst_d = burst_q + CW'(1);
            tmo_d   = '0;
          end else begin
            do_arb = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      default: do_arb = 1'b1;
    endcase
    if (do_arb) begin
      burst_d = '0;
      tmo_d   = '0;
      if (win_vld) begin
        state_d = BUSY;
        gidx_d  = win_idx;
        grant_d = N'(1) << win_idx;
        ptr_d   = (win_idx == IW'(N - 1)) ? '0 : (win_idx + IW'(1));
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a fixed-priority and a round-robin instance, directed
// scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int TO = 15;

  typedef struct packed {
    logic [N-1:0]  grant;
    logic [N-1:0]  ack;
    logic [N-1:0]  err;
    logic          cs;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    logic [DW-1:0] mdat;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [N-1:0]    req [2];
  logic [N-1:0]    lock [2];
  logic [N-1:0]    we [2];
  logic [N*AW-1:0] maddr [2];
  logic [N*DW-1:0] mdat [2];
  logic [DW-1:0]   sdat [2];
  logic            ack_in [2];
  logic [DW-1:0]   mdat_o [2];
  logic [N-1:0]    ack_o [2];
  logic [N-1:0]    err_o [2];
  logic [N-1:0]    grant_o [2];
  logic [AW-1:0]   addr_o [2];
  logic [DW-1:0]   dat_o [2];
  logic            we_o [2];
  logic            cs_o [2];

  int checks;
  int failures;

  // model state: owner (-1 = idle), RR pointer, locked transfers done, wait cycles
  int own [2];
  int ptr [2];
  int nb [2];
  int wc [2];

  bus_arbiter #(.NUM_MASTERS(N), .DW(DW), .AW(AW), .RR_MODE(0), .MAX_BURST(MB), .TIMEOUT(TO)) u_fix (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req[0]), .i_lock(lock[0]), .i_m_addr(maddr[0]),
    .i_m_dat(mdat[0]), .i_m_we(we[0]), .o_m_dat(mdat_o[0]), .o_m_ack(ack_o[0]), .o_m_err(err_o[0]),
    .o_grant(grant_o[0]), .o_addr(addr_o[0]), .o_dat(dat_o[0]), .o_we(we_o[0]), .o_cs(cs_o[0]),
    .i_dat(sdat[0]), .i_ack(ack_in[0]));

  bus_arbiter #(.NUM_MASTERS(N), .DW(DW), .AW(AW), .RR_MODE(1), .MAX_BURST(MB), .TIMEOUT(TO)) u_rr (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req[1]), .i_lock(lock[1]), .i_m_addr(maddr[1]),
    .i_m_dat(mdat[1]), .i_m_we(we[1]), .o_m_dat(mdat_o[1]), .o_m_ack(ack_o[1]), .o_m_err(err_o[1]),
    .o_grant(grant_o[1]), .o_addr(addr_o[1]), .o_dat(dat_o[1]), .o_we(we_o[1]), .o_cs(cs_o[1]),
    .i_dat(sdat[1]), .i_ack(ack_in[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model_out(input int m);
    exp_t e;
    int g;
    e = '0;
    g = own[m];
    if (g >= 0) begin
      e.grant = N'(1) << g;
      e.addr  = maddr[m][g*AW +: AW];
      e.dat   = mdat[m][g*DW +: DW];
      e.cs    = req[m][g];
      e.we    = e.cs & we[m][g];
      if (e.cs && ack_in[m]) e.ack = e.grant;
      else if (e.cs && wc[m] == TO) e.err = e.grant;
    end
    e.mdat = sdat[m];
    return e;
  endfunction

  task automatic model_pick(input int m, input logic [N-1:0] cand);
    int j;
    nb[m] = 0;
    wc[m] = 0;
    own[m] = -1;
    for (int i = 0; i < N; i++) begin
      j = (m == 1) ? (ptr[m] + i) % N : i;
      if (own[m] < 0 && cand[j]) own[m] = j;
    end
    if (own[m] >= 0) ptr[m] = (own[m] + 1) % N;
  endtask

  task automatic model_advance(input int m);
    int g;
    logic [N-1:0] others;
    g = own[m];
    if (!rst_n) begin
      own[m] = -1; ptr[m] = 0; nb[m] = 0; wc[m] = 0;
    end else if (g < 0) begin
      model_pick(m, req[m]);
    end else if (!req[m][g]) begin
      model_pick(m, req[m]);
    end else if (ack_in[m] || wc[m] == TO) begin
      others = req[m] & ~(N'(1) << g);
      if (lock[m][g] && nb[m] + 1 < MB) begin
        nb[m] = nb[m] + 1;
        wc[m] = 0;
      end else if (lock[m][g] && others != '0) begin
        model_pick(m, others);
      end else begin
        model_pick(m, req[m]);
      end
    end else begin
      wc[m] = wc[m] + 1;
    end
  endtask

  // inputs are stable until after the coming edge, so the model can step now
  task automatic next_cycle();
    for (int m = 0; m < 2; m++) model_advance(m);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      req[m] = '0; lock[m] = '0; we[m] = '0; maddr[m] = '0; mdat[m] = '0;
      sdat[m] = '0; ack_in[m] = 1'b0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      req[m] = N'($urandom);
      maddr[m] = (N*AW)'({$urandom, $urandom});
    end
    next_cycle();
    next_cycle();
    #3;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (grant_o[m] !== '0) begin failures++; $display("FAIL reset_grant[%0d]: got %b want 000", m, grant_o[m]); end
      checks++;
      if ({cs_o[m], we_o[m]} !== 2'b00) begin failures++; $display("FAIL reset_cs_we[%0d]: got %b want 00", m, {cs_o[m], we_o[m]}); end
      checks++;
      if ({addr_o[m], dat_o[m], ack_o[m], err_o[m]} !== '0) begin
        failures++; $display("FAIL reset_bus[%0d]: got %h/%h/%b/%b want zeros", m, addr_o[m], dat_o[m], ack_o[m], err_o[m]);
      end
    end
    next_cycle();
    do_reset();
  endtask

  task automatic test_single();
    int nack;
    logic [AW-1:0] a;
    do_reset();
    a = AW'($urandom);
    maddr[0][0 +: AW] = a;
    req[0] = 3'b001;
    nack = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) req[0] = '0;
      ack_in[0] = (c == 3);
      #3;
      if (ack_o[0][0]) nack++;
      case (c)
        0: begin
          checks++;
          if (grant_o[0] !== 3'b000) begin failures++; $display("FAIL single_latency: got %b want 000", grant_o[0]); end
        end
        1: begin
          checks++;
          if (grant_o[0] !== 3'b001) begin failures++; $display("FAIL single_grant: got %b want 001", grant_o[0]); end
          checks++;
          if (cs_o[0] !== 1'b1 || addr_o[0] !== a) begin
            failures++; $display("FAIL single_bus: got cs=%b addr=%h want cs=1 addr=%h", cs_o[0], addr_o[0], a);
          end
        end
        3: begin
          checks++;
          if (ack_o[0] !== 3'b001) begin failures++; $display("FAIL single_ack: got %b want 001", ack_o[0]); end
        end
        4: begin
          checks++;
          if (cs_o[0] !== 1'b0) begin failures++; $display("FAIL single_drop_cs: got %b want 0", cs_o[0]); end
        end
        5: begin
          checks++;
          if (grant_o[0] !== 3'b000) begin failures++; $display("FAIL single_idle: got %b want 000", grant_o[0]); end
        end
        default: ;
      endcase
      next_cycle();
    end
    checks++;
    if (nack != 1) begin failures++; $display("FAIL single_ack_count: got %0d want 1", nack); end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    req[0] = 3'b110;
    ack_in[0] = 1'b1;
    next_cycle();
    for (int c = 0; c < 8; c++) begin
      #3;
      checks++;
      if (grant_o[0] !== 3'b010 || ack_o[0] !== 3'b010) begin
        failures++; $display("FAIL fixed_grant c%0d: got grant=%b ack=%b want 010/010", c, grant_o[0], ack_o[0]);
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want;
    do_reset();
    req[1] = 3'b111;
    ack_in[1] = 1'b1;
    next_cycle();
    for (int c = 0; c < 7; c++) begin
      want = N'(1) << (c % N);
      #3;
      checks++;
      if (grant_o[1] !== want || cs_o[1] !== 1'b1) begin
        failures++; $display("FAIL rr_seq c%0d: got grant=%b cs=%b want %b cs=1", c, grant_o[1], cs_o[1], want);
      end
      next_cycle();
    end
  endtask

  task automatic test_lock_burst();
    int n2;
    do_reset();
    req[0] = 3'b100;
    lock[0] = 3'b100;
    ack_in[0] = 1'b1;
    next_cycle();
    req[0] = 3'b101;
    n2 = 0;
    for (int c = 1; c <= 5; c++) begin
      #3;
      if (ack_o[0][2]) n2++;
      if (c == 5) begin
        checks++;
        if (grant_o[0] !== 3'b001) begin failures++; $display("FAIL burst_release: got %b want 001", grant_o[0]); end
      end
      next_cycle();
    end
    checks++;
    if (n2 != MB) begin failures++; $display("FAIL burst_count: got %0d want %0d", n2, MB); end
    req[0] = 3'b100;
    next_cycle();
    for (int c = 0; c < 12; c++) begin
      #3;
      checks++;
      if (grant_o[0] !== 3'b100 || ack_o[0] !== 3'b100) begin
        failures++; $display("FAIL burst_sole c%0d: got grant=%b ack=%b want 100/100", c, grant_o[0], ack_o[0]);
      end
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    int gcyc, ecyc, nerr, nack;
    logic drop;
    do_reset();
    req[0] = 3'b010;
    gcyc = -1; ecyc = -1; nerr = 0; nack = 0; drop = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (drop) req[0] = '0;
      #3;
      if (gcyc < 0 && grant_o[0] != '0) gcyc = c;
      if (ack_o[0] != '0) nack++;
      if (err_o[0] != '0) begin
        nerr++;
        if (ecyc < 0) ecyc = c;
        checks++;
        if (err_o[0] !== 3'b010) begin failures++; $display("FAIL timeout_onehot: got %b want 010", err_o[0]); end
        drop = 1'b1;
      end
      next_cycle();
    end
    checks++;
    if (nerr != 1) begin failures++; $display("FAIL timeout_err_count: got %0d want 1", nerr); end
    checks++;
    if (ecyc - gcyc != TO) begin failures++; $display("FAIL timeout_delay: got %0d want %0d", ecyc - gcyc, TO); end
    checks++;
    if (nack != 0) begin failures++; $display("FAIL timeout_no_ack: got %0d want 0", nack); end
    #3;
    checks++;
    if (grant_o[0] !== 3'b000) begin failures++; $display("FAIL timeout_release: got %b want 000", grant_o[0]); end
    next_cycle();
  endtask

  task automatic test_abort_reset();
    do_reset();
    req[0] = 3'b001;
    next_cycle();
    #3;
    checks++;
    if (cs_o[0] !== 1'b1) begin failures++; $display("FAIL abort_cs_before: got %b want 1", cs_o[0]); end
    next_cycle();
    req[0] = '0;
    ack_in[0] = 1'b1;
    #3;
    checks++;
    if ({cs_o[0], ack_o[0], err_o[0]} !== 7'b0) begin
      failures++; $display("FAIL abort_late_ack: got cs=%b ack=%b err=%b want 0/000/000", cs_o[0], ack_o[0], err_o[0]);
    end
    next_cycle();
    ack_in[0] = 1'b0;
    req[0] = 3'b001;
    #3;
    checks++;
    if (grant_o[0] !== 3'b000) begin failures++; $display("FAIL abort_release: got %b want 000", grant_o[0]); end
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    #3;
    checks++;
    if (grant_o[0] !== 3'b000 || cs_o[0] !== 1'b0) begin
      failures++; $display("FAIL reset_mid_xfer: got grant=%b cs=%b want 000/0", grant_o[0], cs_o[0]);
    end
    next_cycle();
  endtask

  task automatic test_random();
    logic [N-1:0] pend [2];
    logic [N-1:0] done [2];
    int ackp [2];
    exp_t e, a;
    do_reset();
    for (int m = 0; m < 2; m++) begin pend[m] = '0; done[m] = '0; ackp[m] = 2; end
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      for (int m = 0; m < 2; m++) begin
        if (c % 50 == 0) ackp[m] = int'($urandom_range(0, 3));
        for (int k = 0; k < N; k++) begin
          if (pend[m][k] && (done[m][k] || $urandom_range(0, 39) == 0)) begin
            pend[m][k] = 1'b0;
          end else if (!pend[m][k] && $urandom_range(0, 2) == 0) begin
            pend[m][k] = 1'b1;
            lock[m][k] = 1'($urandom_range(0, 1));
            we[m][k] = 1'($urandom_range(0, 1));
            maddr[m][k*AW +: AW] = AW'($urandom);
            mdat[m][k*DW +: DW] = DW'($urandom);
          end
        end
        req[m] = pend[m];
        ack_in[m] = (ackp[m] != 0) && (int'($urandom_range(1, 4)) <= ackp[m]);
        sdat[m] = DW'($urandom);
      end
      #3;
      for (int m = 0; m < 2; m++) begin
        e = model_out(m);
        a = '{grant: grant_o[m], ack: ack_o[m], err: err_o[m], cs: cs_o[m], we: we_o[m],
              addr: addr_o[m], dat: dat_o[m], mdat: mdat_o[m]};
        checks++;
        if (a.grant !== e.grant) begin
          failures++; $display("FAIL rand_grant[%0d] c%0d: got %b want %b", m, c, a.grant, e.grant);
        end
        checks++;
        if (a !== e) begin
          failures++; $display("FAIL rand_bus[%0d] c%0d: got %h want %h", m, c, a, e);
        end
        done[m] = ack_o[m] | err_o[m];
      end
      next_cycle();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int m = 0; m < 2; m++) begin own[m] = -1; ptr[m] = 0; nb[m] = 0; wc[m] = 0; end
    clear_inputs();
    rst_n = 1'b0;
    next_cycle();
    test_reset();
    test_single();
    test_fixed_priority();
    test_round_robin();
    test_lock_burst();
    test_timeout();
    test_abort_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

endmodule
